// File: rtl/arm_pkg.sv
// Shared register-file geometry and write-back sequencer state encoding.
package arm_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;

  typedef enum logic {
    ONE    = 1'b0,
    SECOND = 1'b1
  } wbseq_state_t;

endpackage : arm_pkg

// File: rtl/wb_write_sequencer.sv
// Serializes up to two register writes per instruction (primary, then base
// update) onto the register file's single write port.
module wb_write_sequencer
  import arm_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_mem_r,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic              in_base_en,
  input  logic [ADDR_W-1:0] in_base_dest,
  input  logic [DATA_W-1:0] in_base_val,
  output logic              writeBackEn,
  output logic [ADDR_W-1:0] destWB,
  output logic [DATA_W-1:0] valueWB,
  output logic              busy
);

  wbseq_state_t      state_q, state_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [ADDR_W-1:0] hold_dest_q, hold_dest_d;
  logic [DATA_W-1:0] hold_val_q, hold_val_d;
  logic [DATA_W-1:0] prim_val;

  assign in_ready = (state_q == ONE);
  assign busy     = !in_ready;

  assign writeBackEn = wb_en_q;
  assign destWB      = dest_q;
  assign valueWB     = value_q;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    state_d     = state_q;
    wb_en_d     = 1'b0;
    dest_d      = dest_q;
    value_d     = value_q;
    hold_dest_d = hold_dest_q;
    hold_val_d  = hold_val_q;
    prim_val    = in_mem_r ? in_mem_data : in_alu_res;

    case (state_q)
      ONE: begin
        if (in_valid) begin
          if (in_wb_en) begin
            wb_en_d = 1'b1;
            dest_d  = in_dest;
            value_d = prim_val;
            // Same destination: the primary value is the architecturally
            // visible one, so the base update is simply dropped.
            if (in_base_en && (in_base_dest != in_dest)) begin
              hold_dest_d = in_base_dest;
              hold_val_d  = in_base_val;
              state_d     = SECOND;
            end
          end else if (in_base_en) begin
            wb_en_d = 1'b1;
            dest_d  = in_base_dest;
            value_d = in_base_val;
          end
        end
      end
      SECOND: begin
        wb_en_d = 1'b1;
        dest_d  = hold_dest_q;
        value_d = hold_val_q;
        state_d = ONE;
      end
      default: state_d = ONE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  // NOTE: the hold register is reset along with the outputs so a reset taken
  // in SECOND cannot leak a stale base write after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ONE;
      wb_en_q     <= 1'b0;
      dest_q      <= '0;
      value_q     <= '0;
      hold_dest_q <= '0;
      hold_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      wb_en_q     <= wb_en_d;
      dest_q      <= dest_d;
      value_q     <= value_d;
      hold_dest_q <= hold_dest_d;
      hold_val_q  <= hold_val_d;
    end
  end

endmodule : wb_write_sequencer

// File: tb/tb_wb_write_sequencer.sv
// Table vectors for the directed cases, hand sequences for reset corners,
// then random instructions checked against a write-list reference model.
module tb_wb_write_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wb_en, in_mem_r, in_base_en;
  logic [3:0]  in_dest, in_base_dest;
  logic [31:0] in_alu_res, in_mem_data, in_base_val;
  logic        writeBackEn, busy;
  logic [3:0]  destWB;
  logic [31:0] valueWB;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_write_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wb_en    (in_wb_en),
    .in_dest     (in_dest),
    .in_mem_r    (in_mem_r),
    .in_alu_res  (in_alu_res),
    .in_mem_data (in_mem_data),
    .in_base_en  (in_base_en),
    .in_base_dest(in_base_dest),
    .in_base_val (in_base_val),
    .writeBackEn (writeBackEn),
    .destWB      (destWB),
    .valueWB     (valueWB),
    .busy        (busy)
  );

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
  } wr_t;

  typedef struct {
    logic        valid;
    logic        wb_en;
    logic [3:0]  dest;
    logic        mem_r;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        base_en;
    logic [3:0]  base_dest;
    logic [31:0] base_val;
    logic        exp_ready;
    logic        exp_we;
    logic [3:0]  exp_dest;
    logic [31:0] exp_val;
  } vec_t;

  // Reference model: writes still owed to the port, and the port's last value.
  wr_t         m_sched[$];
  logic        m_we;
  logic [3:0]  m_dest;
  logic [31:0] m_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sched.delete();
    m_we   = 1'b0;
    m_dest = '0;
    m_val  = '0;
  endtask

  // One clock edge: owed writes go first; otherwise a transfer expands into
  // its list of writes, the first issued now and the rest owed.
  task automatic model_edge();
    wr_t w;
    wr_t q[$];
    if (m_sched.size() > 0) begin
      w = m_sched.pop_front();
      m_we = 1'b1; m_dest = w.d; m_val = w.v;
    end else if (in_valid) begin
      if (in_wb_en) begin
        w.d = in_dest;
        w.v = in_mem_r ? in_mem_data : in_alu_res;
        q.push_back(w);
      end
      if (in_base_en && !(in_wb_en && in_dest == in_base_dest)) begin
        w.d = in_base_dest;
        w.v = in_base_val;
        q.push_back(w);
      end
      if (q.size() == 0) m_we = 1'b0;
      else begin
        m_we = 1'b1; m_dest = q[0].d; m_val = q[0].v;
        for (int i = 1; i < q.size(); i++) m_sched.push_back(q[i]);
      end
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid     = v.valid;
    in_wb_en     = v.wb_en;
    in_dest      = v.dest;
    in_mem_r     = v.mem_r;
    in_alu_res   = v.alu;
    in_mem_data  = v.mem;
    in_base_en   = v.base_en;
    in_base_dest = v.base_dest;
    in_base_val  = v.base_val;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    drive(v);
    #1;
    check($sformatf("tbl%0d_ready", idx), in_ready, v.exp_ready);
    check($sformatf("tbl%0d_busy", idx), busy, !v.exp_ready);
    model_edge();
    @(posedge clk); #1;
    check($sformatf("tbl%0d_we", idx), writeBackEn, v.exp_we);
    if (v.exp_we) begin
      check($sformatf("tbl%0d_dest", idx), destWB, v.exp_dest);
      check($sformatf("tbl%0d_val", idx), valueWB, v.exp_val);
    end
  endtask

  task automatic step_model(input string tag);
    #1;
    check({tag, "_ready"}, in_ready, m_sched.size() == 0);
    check({tag, "_busy"}, busy, m_sched.size() != 0);
    model_edge();
    @(posedge clk); #1;
    check({tag, "_we"}, writeBackEn, m_we);
    check({tag, "_dest"}, destWB, m_dest);
    check({tag, "_val"}, valueWB, m_val);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_we"}, writeBackEn, 1'b0);
    check({tag, "_dest"}, destWB, 4'd0);
    check({tag, "_val"}, valueWB, 32'd0);
    check({tag, "_ready"}, in_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  vec_t tbl[14];
  vec_t idle;

  initial begin
    //          vld wb  dest mr alu           mem           be  bd   bval          rdy we  edst eval
    tbl[0]  = '{1, 1, 4'd3, 0, 32'h0000_1234, 32'h0,        0, 4'd0,  32'h0,   1, 1, 4'd3,  32'h0000_1234};
    tbl[1]  = '{0, 0, 4'd0, 0, 32'h0,         32'h0,        0, 4'd0,  32'h0,   1, 0, 4'd3,  32'h0000_1234};
    tbl[2]  = '{1, 1, 4'd2, 1, 32'h0,         32'hDEAD_BEEF, 1, 4'd5, 32'h104, 1, 1, 4'd2,  32'hDEAD_BEEF};
    tbl[3]  = '{1, 1, 4'd2, 1, 32'h0,         32'hDEAD_BEEF, 1, 4'd5, 32'h104, 0, 1, 4'd5,  32'h104};
    tbl[4]  = '{0, 0, 4'd0, 0, 32'h0,         32'h0,        0, 4'd0,  32'h0,   1, 0, 4'd5,  32'h104};
    tbl[5]  = '{1, 1, 4'd7, 0, 32'hAA,        32'h0,        1, 4'd7,  32'h55,  1, 1, 4'd7,  32'hAA};
    tbl[6]  = '{0, 0, 4'd0, 0, 32'h0,         32'h0,        0, 4'd0,  32'h0,   1, 0, 4'd7,  32'hAA};
    tbl[7]  = '{1, 1, 4'd1, 0, 32'h11,        32'h0,        1, 4'd8,  32'h80,  1, 1, 4'd1,  32'h11};
    tbl[8]  = '{1, 1, 4'd1, 0, 32'h11,        32'h0,        1, 4'd8,  32'h80,  0, 1, 4'd8,  32'h80};
    tbl[9]  = '{1, 1, 4'd9, 1, 32'h0,         32'h99,       1, 4'd10, 32'hA0,  1, 1, 4'd9,  32'h99};
    tbl[10] = '{1, 1, 4'd9, 1, 32'h0,         32'h99,       1, 4'd10, 32'hA0,  0, 1, 4'd10, 32'hA0};
    tbl[11] = '{1, 0, 4'd0, 0, 32'h0,         32'h0,        1, 4'd4,  32'h44,  1, 1, 4'd4,  32'h44};
    tbl[12] = '{1, 0, 4'd2, 0, 32'h77,        32'h0,        0, 4'd6,  32'h66,  1, 0, 4'd4,  32'h44};
    tbl[13] = '{0, 0, 4'd0, 0, 32'h0,         32'h0,        0, 4'd0,  32'h0,   1, 0, 4'd4,  32'h44};
    idle    = '{0, 0, 4'd0, 0, 32'h0,         32'h0,        0, 4'd0,  32'h0,   1, 0, 4'd0,  32'h0};

    // Reset and directed vectors.
    rst = 1'b1;
    drive(idle);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 14; i++) apply_vec(tbl[i], i);

    // Asynchronous reset mid-cycle with a live write on the port.
    drive('{1, 1, 4'd6, 0, 32'h66, 32'h0, 0, 4'd0, 32'h0, 1, 1, 4'd6, 32'h66});
    step_model("pre_async");
    drive(idle);
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    model_reset();
    @(negedge clk) rst = 1'b0;

    // Reset during the bubble cycle discards the deferred base write.
    drive('{1, 1, 4'd2, 0, 32'h22, 32'h0, 1, 4'd3, 32'h33, 1, 1, 4'd2, 32'h22});
    step_model("sec_first");
    check("sec_busy", busy, 1'b1);
    drive(idle);
    #2 rst = 1'b1;
    #1 check_zero_outputs("sec_rst");
    model_reset();
    @(posedge clk); #1;
    check("sec_rst_hold_we", writeBackEn, 1'b0);
    @(negedge clk) rst = 1'b0;
    step_model("sec_after");
    step_model("sec_after2");

    // Random instructions; fields held while stalled.
    for (int n = 0; n < 400; n++) begin
      if (!(in_valid && m_sched.size() > 0)) begin
        in_valid     = ($urandom_range(0, 3) != 0);
        in_wb_en     = $urandom_range(0, 1);
        in_dest      = 4'($urandom_range(0, 3));
        in_mem_r     = $urandom_range(0, 1);
        in_alu_res   = $urandom;
        in_mem_data  = $urandom;
        in_base_en   = $urandom_range(0, 1);
        in_base_dest = 4'($urandom_range(0, 3));
        in_base_val  = $urandom;
      end
      step_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_wb_write_sequencer
